// File: rtl/arith_encoder.sv
// Buffered RISC-V arithmetic instruction encoder: encodes a request into a 32-bit word and
// queues it in a small in-order FIFO. Optional pop counter enabled by ARITH_ENCODER_COUNT_EN.

typedef enum logic [3:0] {
  OpAdd,
  OpSub,
  OpAnd,
  OpOr,
  OpXor,
  OpAddw,
  OpSubw,
  OpAddi,
  OpXori,
  OpOri,
  OpAndi,
  OpAddiw
} alu_operation;

module arith_encoder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  alu_operation in_op,
  input  logic [4:0]   in_rd,
  input  logic [4:0]   in_rs1,
  input  logic [4:0]   in_rs2,
  input  logic [11:0]  in_imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_inst,
  output logic [31:0]  enc_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOp32  = 7'b0111011;
  localparam logic [6:0] OpcImm   = 7'b0010011;
  localparam logic [6:0] OpcImm32 = 7'b0011011;
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Sub    = 7'b0100000;

  logic [31:0]     enc_word;
  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  always_comb begin
    enc_word = 32'h0000_0013;
    case (in_op)
      OpAdd:   enc_word = {F7Base, in_rs2, in_rs1, 3'b000, in_rd, OpcOp};
      OpSub:   enc_word = {F7Sub,  in_rs2, in_rs1, 3'b000, in_rd, OpcOp};
      OpAnd:   enc_word = {F7Base, in_rs2, in_rs1, 3'b111, in_rd, OpcOp};
      OpOr:    enc_word = {F7Base, in_rs2, in_rs1, 3'b110, in_rd, OpcOp};
      OpXor:   enc_word = {F7Base, in_rs2, in_rs1, 3'b100, in_rd, OpcOp};
      OpAddw:  enc_word = {F7Base, in_rs2, in_rs1, 3'b000, in_rd, OpcOp32};
      OpSubw:  enc_word = {F7Sub,  in_rs2, in_rs1, 3'b000, in_rd, OpcOp32};
      OpAddi:  enc_word = {in_imm, in_rs1, 3'b000, in_rd, OpcImm};
      OpXori:  enc_word = {in_imm, in_rs1, 3'b100, in_rd, OpcImm};
      OpOri:   enc_word = {in_imm, in_rs1, 3'b110, in_rd, OpcImm};
      OpAndi:  enc_word = {in_imm, in_rs1, 3'b111, in_rd, OpcImm};
      OpAddiw: enc_word = {in_imm, in_rs1, 3'b000, in_rd, OpcImm32};
      default: ;
    endcase
  end

  // Handshake status depends on occupancy only; a pop never frees a slot for the same cycle.
  assign in_ready  = count_q != CntW'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_inst  = out_valid ? mem_q[rptr_q] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: out_inst is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= enc_word;
  end

`ifdef ARITH_ENCODER_COUNT_EN
  logic [31:0] enc_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_count_q <= '0;
    end else if (pop) begin
      enc_count_q <= enc_count_q + 32'd1;
    end
  end

  assign enc_count = enc_count_q;
`else
  assign enc_count = '0;
`endif

endmodule

// File: tb/tb_arith_encoder.sv
// Self-checking bench for arith_encoder: table-driven encodings plus FIFO backpressure,
// full pop/push and mid-cycle reset sequences.

module tb_arith_encoder;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  alu_operation in_op;
  logic [4:0]   in_rd, in_rs1, in_rs2;
  logic [11:0]  in_imm;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_inst;
  logic [31:0]  enc_count;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef ARITH_ENCODER_COUNT_EN
  localparam logic [31:0] ExpPops = 32'd5;
`else
  localparam logic [31:0] ExpPops = 32'd0;
`endif

  typedef struct {
    alu_operation op;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [11:0]  imm;
    logic [31:0]  exp;
  } vec_t;

  localparam int NVec = 13;
  vec_t vecs [NVec];

  arith_encoder #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input int k);
    in_op  = vecs[k].op;
    in_rd  = vecs[k].rd;
    in_rs1 = vecs[k].rs1;
    in_rs2 = vecs[k].rs2;
    in_imm = vecs[k].imm;
  endtask

  initial begin
    vecs[0]  = '{OpAdd,   5'd1,  5'd2,  5'd3,  12'h000, 32'h003100B3};
    vecs[1]  = '{OpAddi,  5'd5,  5'd0,  5'd7,  12'hFFF, 32'hFFF00293};
    vecs[2]  = '{OpSubw,  5'd10, 5'd11, 5'd12, 12'h000, 32'h40C5853B};
    vecs[3]  = '{OpSub,   5'd1,  5'd2,  5'd3,  12'h000, 32'h403100B3};
    vecs[4]  = '{OpAnd,   5'd1,  5'd2,  5'd3,  12'h000, 32'h003170B3};
    vecs[5]  = '{OpOr,    5'd1,  5'd2,  5'd3,  12'h000, 32'h003160B3};
    vecs[6]  = '{OpXor,   5'd1,  5'd2,  5'd3,  12'h000, 32'h003140B3};
    vecs[7]  = '{OpAddw,  5'd1,  5'd2,  5'd3,  12'h000, 32'h003100BB};
    vecs[8]  = '{OpXori,  5'd5,  5'd0,  5'd9,  12'h123, 32'h12304293};
    vecs[9]  = '{OpOri,   5'd3,  5'd4,  5'd0,  12'h7FF, 32'h7FF26193};
    vecs[10] = '{OpAndi,  5'd31, 5'd31, 5'd31, 12'h800, 32'h800FFF93};
    vecs[11] = '{OpAddiw, 5'd2,  5'd3,  5'd0,  12'h001, 32'h0011811B};
    vecs[12] = '{alu_operation'(4'd15), 5'd7, 5'd8, 5'd9, 12'hABC, 32'h00000013};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(0);
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_inst", out_inst, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset enc_count", enc_count, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // One push per vector, popped immediately.
    for (int i = 0; i < NVec; i++) begin
      drive(i);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d out_inst", i), out_inst, vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: three pushes into DEPTH=2 with the consumer stalled.
    out_ready = 1'b0;
    drive(0);
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b ready after 1", {31'd0, in_ready}, 32'd1);
    drive(1);
    @(negedge clk);
    check("b2b full in_ready", {31'd0, in_ready}, 32'd0);
    drive(2);
    @(negedge clk);
    check("b2b still full", {31'd0, in_ready}, 32'd0);
    check("b2b head stable", out_inst, vecs[0].exp);
    // Full with pop and push both requested: only the pop happens.
    out_ready = 1'b1;
    @(negedge clk);
    check("full pop ready back", {31'd0, in_ready}, 32'd1);
    check("full pop out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b second word", out_inst, vecs[1].exp);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b third word", out_inst, vecs[2].exp);
    check("b2b occupancy 1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("b2b drained", {31'd0, out_valid}, 32'd0);

    // Mid-cycle asynchronous reset with one word in flight.
    out_ready = 1'b0;
    drive(5);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid reset out_inst", out_inst, 32'd0);
    check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    check("mid reset enc_count", enc_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Five pops after reset; the first push after release must be the first word out.
    for (int k = 0; k < 5; k++) begin
      drive(k + 1);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("post-reset word%0d", k), out_inst, vecs[k + 1].exp);
      @(negedge clk);
    end
    check("enc_count after 5 pops", enc_count, ExpPops);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
